xfrm_pipe_scheduler: RTL and testbench

// - Sequences the ColorTransform FIFO -> Homography -> sync_controller pixel pipeline for one frame.
// - Issues rdreq to the FIFO and tracks pixels in flight against Homography ready returns.
// - Keeps in-flight depth within the 3-stage alignment buffer of the sync stage.
// - Holds raster position, detects frame end, drain, timeout and underflow.

---
 rtl/xfrm_sched_pkg.sv | 27 ++
 rtl/xfrm_pipe_scheduler_raster_counter.sv | 57 +++++
 rtl/xfrm_pipe_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_xfrm_pipe_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xfrm_sched_pkg.sv
// ----------------------------------------------------------------------------
// xfrm_sched_pkg
// Shared types and defaults for the ColorTransform FIFO -> Homography ->
// sync_controller pixel pipeline scheduler.
//   DEF_H_ACTIVE / DEF_V_ACTIVE : default active raster size
//   DEF_MAX_INFLIGHT            : sync-stage alignment buffer depth
//   DEF_TIMEOUT                 : stall cycles tolerated before abort
//   coord_t                     : 10-bit raster coordinate
//   sched_state_t               : scheduler FSM states
// ----------------------------------------------------------------------------
package xfrm_sched_pkg;

    localparam int unsigned DEF_H_ACTIVE     = 640;
    localparam int unsigned DEF_V_ACTIVE     = 480;
    localparam int unsigned DEF_MAX_INFLIGHT = 3;
    localparam int unsigned DEF_TIMEOUT      = 15;

    typedef logic [9:0] coord_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/xfrm_pipe_scheduler_raster_counter.sv
// ----------------------------------------------------------------------------
// raster_counter
// x/y position of the next pixel to issue. Advances one pixel per i_adv,
// wrapping x at H_ACTIVE-1 and y at V_ACTIVE-1.
//   clk_25  in  pixel clock
//   rst_n   in  asynchronous active-low reset
//   i_clr   in  synchronous clear to (0,0)
//   i_adv   in  advance one pixel
//   o_x     out current x
//   o_y     out current y
//   o_last  out current position is the final pixel of the frame
// ----------------------------------------------------------------------------
module raster_counter
    import xfrm_sched_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE
) (
    input  logic   clk_25,
    input  logic   rst_n,
    input  logic   i_clr,
    input  logic   i_adv,
    output coord_t o_x,
    output coord_t o_y,
    output logic   o_last
);

    coord_t r_x;
    coord_t r_y;
    logic   w_x_end;
    logic   w_y_end;

    assign w_x_end = (r_x == coord_t'(H_ACTIVE - 1));
    assign w_y_end = (r_y == coord_t'(V_ACTIVE - 1));

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clr) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_adv) begin
            if (w_x_end) begin
                r_x <= '0;
                r_y <= w_y_end ? '0 : r_y + coord_t'(1);
            end else begin
                r_x <= r_x + coord_t'(1);
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = w_x_end & w_y_end;

endmodule

// File: rtl/xfrm_pipe_scheduler.sv
// ----------------------------------------------------------------------------
// xfrm_pipe_scheduler
// Sequences one frame through the ColorTransform FIFO -> Homography ->
// sync_controller pipeline: issues FIFO reads, tracks pixels in flight
// against Homography ready returns (bounded by the sync-stage alignment
// depth), tracks raster position and detects frame end, drain, timeout
// and underflow.
// Optional feature: define STALL_STAT_EN to enable the stall_cnt counter;
// otherwise stall_cnt is tied to zero.
//   clk_25        in   pixel clock
//   rst_n         in   asynchronous active-low reset
//   start         in   begin frame pulse (accepted only in IDLE)
//   fifo_empty    in   ColorTransform FIFO empty
//   sink_ready    in   downstream can accept a pixel
//   ready         in   Homography result valid
//   rdreq         out  FIFO read strobe
//   pix_x/pix_y   out  coordinate of next pixel to issue
//   inflight      out  issued minus returned
//   busy          out  RUN or DRAIN
//   frame_done    out  one-cycle pulse on clean completion
//   err_timeout   out  sticky abort flag
//   err_underflow out  sticky ready-with-nothing-in-flight flag
//   stall_cnt     out  RUN cycles with FIFO data but no read
// ----------------------------------------------------------------------------
module xfrm_pipe_scheduler
    import xfrm_sched_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = DEF_MAX_INFLIGHT,
    parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
    parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
    input  logic        clk_25,
    input  logic        rst_n,
    input  logic        start,
    input  logic        fifo_empty,
    input  logic        sink_ready,
    input  logic        ready,
    output logic        rdreq,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [1:0]  inflight,
    output logic        busy,
    output logic        frame_done,
    output logic        err_timeout,
    output logic        err_underflow,
    output logic [15:0] stall_cnt
);

    localparam logic [1:0] LP_MAX_INFL = 2'(MAX_INFLIGHT);
    localparam logic [3:0] LP_TMO_LAST = 4'(TIMEOUT - 1);

    sched_state_t r_state;
    sched_state_t w_state_nxt;

    logic [1:0] r_inflight;
    logic [3:0] r_tmo;
    logic       r_err_to;
    logic       r_err_un;

    logic       w_accept_start;
    logic       w_issue;
    logic       w_return;
    logic       w_tmo_run;
    logic       w_tmo_hit;
    logic       w_last;

    assign w_accept_start = (r_state == IDLE) & start;

    // A ready in the same cycle frees a credit, so a full pipe can still issue.
    assign w_issue  = (r_state == RUN) & ~fifo_empty & sink_ready
                    & ((r_inflight < LP_MAX_INFL) | ready);

    // Ready with nothing outstanding is an underflow, not a return.
    assign w_return = ready & (r_inflight != 2'd0);

    assign w_tmo_run = ((r_state == RUN) | (r_state == DRAIN))
                     & (r_inflight != 2'd0) & ~ready;
    // Abort on the edge where the counter would reach TIMEOUT.
    assign w_tmo_hit = w_tmo_run & (r_tmo == LP_TMO_LAST);

    raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_raster (
        .clk_25 (clk_25),
        .rst_n  (rst_n),
        .i_clr  (w_accept_start),
        .i_adv  (w_issue),
        .o_x    (pix_x),
        .o_y    (pix_y),
        .o_last (w_last)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_tmo_hit)             w_state_nxt = IDLE;
                else if (w_issue & w_last) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_tmo_hit)                 w_state_nxt = IDLE;
                else if (r_inflight == 2'd0)   w_state_nxt = DONE;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        rdreq      = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        unique case (r_state)
            RUN: begin
                rdreq = w_issue;
                busy  = 1'b1;
            end
            DRAIN: busy = 1'b1;
            DONE:  frame_done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- in-flight tracking ----------------
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else if (w_accept_start | w_tmo_hit) begin
            r_inflight <= '0;
        end else begin
            unique case ({w_issue, w_return})
                2'b10:   r_inflight <= r_inflight + 2'd1;
                2'b01:   r_inflight <= r_inflight - 2'd1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // ---------------- timeout counter ----------------
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= '0;
        end else if (w_tmo_run & ~w_tmo_hit) begin
            r_tmo <= r_tmo + 4'd1;
        end else begin
            r_tmo <= '0;
        end
    end

    // ---------------- sticky error flags ----------------
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_err_to <= 1'b0;
            r_err_un <= 1'b0;
        end else if (w_accept_start) begin
            r_err_to <= 1'b0;
            r_err_un <= 1'b0;
        end else begin
            if (w_tmo_hit)                        r_err_to <= 1'b1;
            if (ready & (r_inflight == 2'd0))     r_err_un <= 1'b1;
        end
    end

    assign inflight      = r_inflight;
    assign err_timeout   = r_err_to;
    assign err_underflow = r_err_un;

    // ---------------- stall statistics ----------------
`ifdef STALL_STAT_EN
    logic [15:0] r_stall;

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (w_accept_start) begin
            r_stall <= '0;
        end else if ((r_state == RUN) & ~w_issue & ~fifo_empty & (r_stall != '1)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign stall_cnt = r_stall;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_xfrm_pipe_scheduler.sv
// ----------------------------------------------------------------------------
// tb_xfrm_pipe_scheduler
// Self-checking bench for xfrm_pipe_scheduler on a reduced raster.
// The reference model tracks the frame as a linear pixel index and an
// outstanding-pixel count; all outputs are compared every cycle.
// ----------------------------------------------------------------------------
module tb_xfrm_pipe_scheduler;

    localparam int H    = 12;
    localparam int V    = 5;
    localparam int NPIX = H * V;
    localparam int MAXF = 3;
    localparam int TMO  = 15;

    localparam int MD_IDLE  = 0;
    localparam int MD_RUN   = 1;
    localparam int MD_DRAIN = 2;
    localparam int MD_DONE  = 3;

    logic        clk_25 = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        sink_ready = 1'b0;
    logic        ready = 1'b0;
    logic        rdreq;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [1:0]  inflight;
    logic        busy;
    logic        frame_done;
    logic        err_timeout;
    logic        err_underflow;
    logic [15:0] stall_cnt;

    always #20 clk_25 = ~clk_25;

    xfrm_pipe_scheduler #(
        .MAX_INFLIGHT (MAXF),
        .H_ACTIVE     (H),
        .V_ACTIVE     (V),
        .TIMEOUT      (TMO)
    ) dut (
        .clk_25        (clk_25),
        .rst_n         (rst_n),
        .start         (start),
        .fifo_empty    (fifo_empty),
        .sink_ready    (sink_ready),
        .ready         (ready),
        .rdreq         (rdreq),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .inflight      (inflight),
        .busy          (busy),
        .frame_done    (frame_done),
        .err_timeout   (err_timeout),
        .err_underflow (err_underflow),
        .stall_cnt     (stall_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_mode, m_pix, m_infl, m_tmo, m_stall;
    bit m_eto, m_eun;
    bit last_iss;
    int n_rdreq = 0;
    int n_done  = 0;

    function automatic bit m_rdreq();
        return (m_mode == MD_RUN) && !fifo_empty && sink_ready && ((m_infl < MAXF) || ready);
    endfunction

    task automatic model_reset();
        m_mode = MD_IDLE; m_pix = 0; m_infl = 0; m_tmo = 0; m_stall = 0;
        m_eto = 0; m_eun = 0;
    endtask

    task automatic model_step();
        bit iss, act;
        int old_infl;
        iss = m_rdreq();
        last_iss = iss;
        if (m_mode == MD_IDLE && start) begin
            m_mode = MD_RUN; m_pix = 0; m_infl = 0; m_tmo = 0; m_stall = 0;
            m_eto = 0; m_eun = 0;
            return;
        end
        act = (m_mode == MD_RUN) || (m_mode == MD_DRAIN);
        old_infl = m_infl;
        if (ready && old_infl == 0) m_eun = 1;
        m_infl = old_infl + (iss ? 1 : 0) - ((ready && old_infl > 0) ? 1 : 0);
`ifdef STALL_STAT_EN
        if (m_mode == MD_RUN && !iss && !fifo_empty && m_stall < 65535) m_stall++;
`endif
        if (iss) m_pix = (m_pix + 1) % NPIX;
        if (act && old_infl > 0 && !ready) m_tmo++;
        else m_tmo = 0;
        if (act && m_tmo == TMO) begin
            m_eto = 1; m_infl = 0; m_mode = MD_IDLE; m_tmo = 0;
        end else begin
            case (m_mode)
                MD_RUN:   if (iss && m_pix == 0) m_mode = MD_DRAIN;
                MD_DRAIN: if (old_infl == 0) m_mode = MD_DONE;
                MD_DONE:  m_mode = MD_IDLE;
                default: ;
            endcase
        end
    endtask

    task automatic compare_all(input string pfx);
        check({pfx, ".rdreq"},      32'(rdreq),         32'(m_rdreq()));
        check({pfx, ".pix_x"},      32'(pix_x),         32'(m_pix % H));
        check({pfx, ".pix_y"},      32'(pix_y),         32'(m_pix / H));
        check({pfx, ".inflight"},   32'(inflight),      32'(m_infl));
        check({pfx, ".busy"},       32'(busy),          32'((m_mode == MD_RUN) || (m_mode == MD_DRAIN)));
        check({pfx, ".frame_done"}, 32'(frame_done),    32'(m_mode == MD_DONE));
        check({pfx, ".err_to"},     32'(err_timeout),   32'(m_eto));
        check({pfx, ".err_un"},     32'(err_underflow), 32'(m_eun));
        check({pfx, ".stall"},      32'(stall_cnt),     32'(m_stall));
    endtask

    // Inputs are applied just after a rising edge; checks happen at the falling edge.
    task automatic cycle(input string pfx, input bit s, input bit fe, input bit sr, input bit rd);
        start = s; fifo_empty = fe; sink_ready = sr; ready = rd;
        @(negedge clk_25);
        compare_all(pfx);
        if (rdreq === 1'b1) n_rdreq++;
        if (frame_done === 1'b1) n_done++;
        model_step();
        @(posedge clk_25);
        #1;
    endtask

    task automatic run_random(input string pfx, input int budget);
        int k;
        k = 0;
        while (m_mode != MD_IDLE && k < budget) begin
            cycle(pfx, ($urandom % 20) == 0, ($urandom % 5) == 0, ($urandom % 6) != 0,
                  (m_infl > 0) && (($urandom % 3) != 0));
            k++;
        end
        check({pfx, ".bound"}, 32'(busy), 32'(0));
    endtask

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_rd, base_done, k;
        bit [2:0] hist;
        bit wrap_seen, drain_seen;

        // ---- reset ----
        model_reset();
        repeat (3) @(posedge clk_25);
        #1;
        compare_all("reset");
        rst_n = 1'b1;

        // ---- underflow in IDLE ----
        cycle("uf", 0, 1, 0, 1);
        cycle("uf", 0, 1, 0, 0);
        check("uf.flag", 32'(err_underflow), 32'(1));
        check("uf.infl", 32'(inflight), 32'(0));

        // ---- smoke: full frame, ready 3 cycles after each rdreq ----
        base_rd = n_rdreq; base_done = n_done;
        hist = '0; wrap_seen = 0; drain_seen = 0;
        cycle("smoke", 1, 0, 1, 0);
        k = 0;
        while (n_done == base_done && k < 2000) begin
            cycle("smoke", 0, 0, 1, hist[2]);
            hist = {hist[1:0], last_iss};
            if (!wrap_seen && m_mode == MD_RUN && m_pix == H) begin
                wrap_seen = 1;
                check("wrap.x", 32'(pix_x), 32'(0));
                check("wrap.y", 32'(pix_y), 32'(1));
            end
            if (!drain_seen && m_mode == MD_DRAIN) begin
                drain_seen = 1;
                check("drain.rdreq", 32'(rdreq), 32'(0));
                check("drain.busy",  32'(busy),  32'(1));
            end
            k++;
        end
        cycle("smoke", 0, 0, 1, 0);
        check("smoke.n_rdreq", 32'(n_rdreq - base_rd), 32'(NPIX));
        check("smoke.n_done",  32'(n_done - base_done), 32'(1));
        check("smoke.err_to",  32'(err_timeout), 32'(0));
        check("smoke.err_un",  32'(err_underflow), 32'(0));

        // ---- credit limit and simultaneous issue/return ----
        cycle("credit", 1, 0, 1, 0);
        base_rd = n_rdreq;
        repeat (5) cycle("credit", 0, 0, 1, 0);
        check("credit.n_rdreq", 32'(n_rdreq - base_rd), 32'(3));
        check("credit.infl",    32'(inflight), 32'(3));
        check("credit.blocked", 32'(rdreq), 32'(0));
        base_rd = n_rdreq;
        cycle("simul", 0, 0, 1, 1);
        check("simul.n_rdreq", 32'(n_rdreq - base_rd), 32'(1));
        check("simul.infl",    32'(inflight), 32'(3));

        // ---- timeout from a full pipe ----
        base_done = n_done; k = 0;
        while (m_mode != MD_IDLE && k < 40) begin
            cycle("tmo3", 0, 0, 1, 0);
            k++;
        end
        check("tmo3.err",  32'(err_timeout), 32'(1));
        check("tmo3.busy", 32'(busy), 32'(0));
        check("tmo3.infl", 32'(inflight), 32'(0));
        check("tmo3.done", 32'(n_done - base_done), 32'(0));

        // ---- timeout with 2 in flight ----
        cycle("tmo2", 1, 0, 1, 0);
        cycle("tmo2", 0, 0, 1, 0);
        cycle("tmo2", 0, 0, 1, 0);
        check("tmo2.infl2", 32'(inflight), 32'(2));
        k = 0;
        while (m_mode != MD_IDLE && k < 40) begin
            cycle("tmo2", 0, 1, 1, 0);
            k++;
        end
        check("tmo2.cycles", 32'(k), 32'(TMO - 1));
        check("tmo2.err",    32'(err_timeout), 32'(1));
        check("tmo2.busy",   32'(busy), 32'(0));
        check("tmo2.infl",   32'(inflight), 32'(0));
        check("tmo2.done",   32'(n_done - base_done), 32'(0));

        // ---- next start clears error; stall statistics ----
        cycle("stall", 1, 1, 1, 0);
        check("restart.err", 32'(err_timeout), 32'(0));
        repeat (10) cycle("stall", 0, 0, 0, 0);
`ifdef STALL_STAT_EN
        check("stall.cnt", 32'(stall_cnt), 32'(10));
`else
        check("stall.cnt", 32'(stall_cnt), 32'(0));
`endif
        cycle("stall", 1, 0, 0, 0);
        check("busy_start.ignored", 32'(pix_x), 32'(0));
        run_random("rnd0", 3000);

        // ---- asynchronous reset mid-frame ----
        cycle("rst", 1, 0, 1, 0);
        repeat (20) cycle("rst", 0, ($urandom % 5) == 0, 1, (m_infl > 0) && (($urandom % 2) == 0));
        start = 0; ready = 0;
        #5;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("midrst");
        @(posedge clk_25);
        #1;
        rst_n = 1'b1;
        cycle("midrst", 0, 0, 1, 0);

        // ---- randomized frames ----
        for (int f = 0; f < 4; f++) begin
            cycle("rnd", 1, ($urandom % 5) == 0, 1, 0);
            run_random("rnd", 3000);
            repeat (2) cycle("rnd", 0, 1, 1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
